// File: rtl/grant_decoder_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : grant_decoder_seq
// Purpose  : Receive end of the 3-channel priority-encode path. It accepts a
//            one-hot grant code (100=ch2, 010=ch1, 001=ch0, 000=none) and
//            checks that the code is legal. It then decodes the code to a
//            binary channel index and runs a fixed-length service window on
//            the granted channel. A one-cycle acknowledge is returned to that
//            channel when the window ends.
// Ports    : clk           - rising-edge clock
//            rst_n         - asynchronous active-low reset
//            grant_code    - one-hot grant from the encoder
//            grant_valid   - grant_code is valid this cycle
//            grant_ready   - block can accept a grant (IDLE only)
//            err_clear     - clears the sticky error flag
//            chan_idx      - binary index of the channel in service
//            chan_active   - one-hot enable, high for BURST_LEN cycles
//            service_busy  - high in SERVICE and ACK
//            ack           - one-cycle one-hot completion pulse
//            err_illegal   - sticky flag: a multi-hot code was offered
//            svc_count     - (GRANT_DEC_STATS_EN only) per-channel saturating
//                            completion counters {ch2, ch1, ch0}
// Options  : `define GRANT_DEC_STATS_EN adds the svc_count statistics port.
// Revision : 1.0 - initial release
// ============================================================================
module grant_decoder_seq #(
  parameter int BURST_LEN = 4,  // service window length, 1..15
  parameter int CNT_W     = 4   // burst counter width, 2**CNT_W > BURST_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  grant_code,
  input  logic        grant_valid,
  output logic        grant_ready,
  input  logic        err_clear,
  output logic [1:0]  chan_idx,
  output logic [2:0]  chan_active,
  output logic        service_busy,
  output logic [2:0]  ack,
  output logic        err_illegal
`ifdef GRANT_DEC_STATS_EN
  ,
  output logic [23:0] svc_count
`endif
);

  localparam logic [1:0]       c_st_idle    = 2'd0;
  localparam logic [1:0]       c_st_service = 2'd1;
  localparam logic [1:0]       c_st_ack     = 2'd2;
  localparam logic [CNT_W-1:0] c_cnt_load   = CNT_W'(BURST_LEN - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_chan_idx;
  logic             r_err;

  logic             w_xfer;
  logic             w_is_onehot;
  logic             w_is_multi;
  logic [1:0]       w_dec_idx;
  logic [2:0]       w_idx_onehot;

  // Only IDLE raises grant_ready, so a transfer can only happen in IDLE.
  assign w_xfer = grant_valid & grant_ready;

  // Grant code legality and binary decode.
  always_comb begin
    w_is_onehot = 1'b1;
    w_dec_idx   = 2'd0;
    case (grant_code)
      3'b001:  w_dec_idx = 2'd0;
      3'b010:  w_dec_idx = 2'd1;
      3'b100:  w_dec_idx = 2'd2;
      default: w_is_onehot = 1'b0;
    endcase
  end

  // 000 is a legal "no grant"; anything else that is not one-hot is illegal.
  assign w_is_multi = (grant_code != 3'b000) && !w_is_onehot;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:    if (w_xfer && w_is_onehot) w_state_nxt = c_st_service;
      c_st_service: if (r_cnt == '0)           w_state_nxt = c_st_ack;
      c_st_ack:                                w_state_nxt = c_st_idle;
      default:                                 w_state_nxt = c_st_idle;
    endcase
  end

  // Output logic. All outputs derive from registered state, so an
  // asynchronous reset drops them immediately.
  assign w_idx_onehot = 3'b001 << r_chan_idx;

  always_comb begin
    grant_ready  = 1'b0;
    service_busy = 1'b0;
    chan_active  = 3'b000;
    ack          = 3'b000;
    case (r_state)
      c_st_idle: begin
        grant_ready = 1'b1;
      end
      c_st_service: begin
        service_busy = 1'b1;
        chan_active  = w_idx_onehot;
      end
      c_st_ack: begin
        service_busy = 1'b1;
        ack          = w_idx_onehot;
      end
      default: begin
        grant_ready = 1'b0;
      end
    endcase
  end

  assign chan_idx    = r_chan_idx;
  assign err_illegal = r_err;

  // Burst counter, channel index latch and sticky error flag. The counter is
  // loaded with BURST_LEN-1 so that SERVICE spans counts BURST_LEN-1 .. 0,
  // which is exactly BURST_LEN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_chan_idx <= 2'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_xfer && w_is_onehot) begin
        r_cnt      <= c_cnt_load;
        r_chan_idx <= w_dec_idx;
      end else if (r_state == c_st_service && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // A new illegal transfer takes priority over a clear in the same cycle.
      if (w_xfer && w_is_multi) begin
        r_err <= 1'b1;
      end else if (err_clear) begin
        r_err <= 1'b0;
      end
    end
  end

`ifdef GRANT_DEC_STATS_EN
  // Per-channel completed-service counters, saturating at 255.
  for (genvar gi = 0; gi < 3; gi++) begin : g_svc_cnt
    logic [7:0] r_svc;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_svc <= 8'd0;
      end else if (ack[gi] && r_svc != 8'hFF) begin
        r_svc <= r_svc + 8'd1;
      end
    end

    assign svc_count[gi*8 +: 8] = r_svc;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_grant_decoder_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_grant_decoder_seq
// Purpose  : Scoreboard testbench for grant_decoder_seq (BURST_LEN=4).
//            Stimulus pushes the expected ack/index of each accepted grant.
//            A monitor pops an entry for every ack pulse and checks the
//            length of the preceding chan_active window.
// Options  : `define GRANT_DEC_STATS_EN also exercises svc_count saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grant_decoder_seq;

  localparam int BURST_LEN = 4;

  typedef struct packed {
    logic [2:0] ack;
    logic [1:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  grant_code = 3'b000;
  logic        grant_valid = 1'b0;
  logic        grant_ready;
  logic        err_clear = 1'b0;
  logic [1:0]  chan_idx;
  logic [2:0]  chan_active;
  logic        service_busy;
  logic [2:0]  ack;
  logic        err_illegal;
`ifdef GRANT_DEC_STATS_EN
  logic [23:0] svc_count;
`endif

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          run_len = 0;
  logic [2:0]  run_val = 3'b000;

  always #5 clk = ~clk;

  grant_decoder_seq #(.BURST_LEN(BURST_LEN), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .grant_code   (grant_code),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready),
    .err_clear    (err_clear),
    .chan_idx     (chan_idx),
    .chan_active  (chan_active),
    .service_busy (service_busy),
    .ack          (ack),
    .err_illegal  (err_illegal)
`ifdef GRANT_DEC_STATS_EN
    ,
    .svc_count    (svc_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (grant_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (grant_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: grant_ready timeout got %b required 1", name, grant_ready);
    end
  endtask

  task automatic send_grant(input logic [2:0] code, input logic [2:0] eack, input logic [1:0] eidx);
    wait_ready("send_grant");
    exp_q.push_back(exp_t'{ack: eack, idx: eidx});
    grant_code  = code;
    grant_valid = 1'b1;
    step();
    grant_valid = 1'b0;
    grant_code  = 3'b000;
  endtask

  // Monitor: checks every ack pulse against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
      run_val = 3'b000;
    end else begin
      if (chan_active != 3'b000) begin
        if (run_len == 0) run_val = chan_active;
        run_len++;
      end
      if (ack != 3'b000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected: got ack=%b required none", ack);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (ack !== e.ack || chan_idx !== e.idx || run_len != BURST_LEN || run_val !== e.ack) begin
            errors++;
            $display("FAIL ack_check: got ack=%b idx=%0d active=%b x%0d required ack=%b idx=%0d active=%b x%0d",
                     ack, chan_idx, run_val, run_len, e.ack, e.idx, e.ack, BURST_LEN);
          end
        end
        run_len = 0;
        run_val = 3'b000;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  32'(grant_ready),  32'd1);
    chk("rst_idx",    32'(chan_idx),     32'd0);
    chk("rst_active", 32'(chan_active),  32'd0);
    chk("rst_ack",    32'(ack),          32'd0);
    chk("rst_busy",   32'(service_busy), 32'd0);
    chk("rst_err",    32'(err_illegal),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Single ch1 grant and latency
    exp_q.push_back(exp_t'{ack: 3'b010, idx: 2'd1});
    grant_code  = 3'b010;
    grant_valid = 1'b1;
    step();
    grant_valid = 1'b0;
    grant_code  = 3'b000;
    @(negedge clk);
    chk("t1_idx",    32'(chan_idx),     32'd1);
    chk("t1_active", 32'(chan_active),  32'b010);
    chk("t1_busy",   32'(service_busy), 32'd1);
    chk("t1_ready",  32'(grant_ready),  32'd0);
    n = 1;
    while (grant_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t1_ready_latency", 32'(n), 32'(BURST_LEN + 2));
    step();

    // Null grant: no action
    grant_code  = 3'b000;
    grant_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("null_ready",  32'(grant_ready),  32'd1);
      chk("null_busy",   32'(service_busy), 32'd0);
      chk("null_active", 32'(chan_active),  32'd0);
      chk("null_err",    32'(err_illegal),  32'd0);
    end
    step();
    grant_valid = 1'b0;

    // Illegal multi-hot grant
    grant_code  = 3'b110;
    grant_valid = 1'b1;
    step();
    grant_valid = 1'b0;
    grant_code  = 3'b000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("ill_err",    32'(err_illegal), 32'd1);
      chk("ill_active", 32'(chan_active), 32'd0);
      chk("ill_ready",  32'(grant_ready), 32'd1);
    end
    step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    @(negedge clk);
    chk("err_cleared", 32'(err_illegal), 32'd0);
    step();
    err_clear   = 1'b1;
    grant_code  = 3'b101;
    grant_valid = 1'b1;
    step();
    err_clear   = 1'b0;
    grant_valid = 1'b0;
    grant_code  = 3'b000;
    @(negedge clk);
    chk("err_set_wins",    32'(err_illegal), 32'd1);
    chk("err_set_active",  32'(chan_active), 32'd0);
    step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    @(negedge clk);
    chk("err_cleared2", 32'(err_illegal), 32'd0);
    step();

    // ch2 grant, then ch0 held valid throughout the burst
    exp_q.push_back(exp_t'{ack: 3'b100, idx: 2'd2});
    exp_q.push_back(exp_t'{ack: 3'b001, idx: 2'd0});
    grant_code  = 3'b100;
    grant_valid = 1'b1;
    step();
    grant_code  = 3'b001;
    @(negedge clk);
    chk("hold_active_ch2", 32'(chan_active), 32'b100);
    chk("hold_ready_busy", 32'(grant_ready), 32'd0);
    n = 1;
    while (grant_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_accept_cycle", 32'(n), 32'(BURST_LEN + 2));
    @(posedge clk);
    #1;
    grant_valid = 1'b0;
    grant_code  = 3'b000;
    @(negedge clk);
    chk("hold_idx_ch0",    32'(chan_idx),    32'd0);
    chk("hold_active_ch0", 32'(chan_active), 32'b001);
    wait_ready("hold_done");

    // Reset in the second SERVICE cycle aborts the burst
    grant_code  = 3'b001;
    grant_valid = 1'b1;
    step();
    grant_valid = 1'b0;
    grant_code  = 3'b000;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_active", 32'(chan_active),  32'd0);
    chk("arst_ack",    32'(ack),          32'd0);
    chk("arst_busy",   32'(service_busy), 32'd0);
    chk("arst_ready",  32'(grant_ready),  32'd1);
    chk("arst_idx",    32'(chan_idx),     32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("arst_no_ack", 32'(ack), 32'd0);
    end
    step();

`ifdef GRANT_DEC_STATS_EN
    // Saturating statistics
    for (int i = 0; i < 300; i++) begin
      send_grant(3'b010, 3'b010, 2'd1);
    end
    wait_ready("stats_done");
    step();
    chk("svc_count_sat", 32'(svc_count), 32'h00FF00);
`endif

    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending acks required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
